// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Groups the decode-stage signals of the register file and scoreboard into one
// bundle.
//
// Parameters:
//   WIDTH  - register data width
//   ADDR_W - register address width (depth = 2**ADDR_W)
//
// Signals:
//   ctrl_writeEnable / ctrl_writeReg / data_writeReg : write port
//   ctrl_readRegA / data_readRegA                    : read port A
//   ctrl_readRegB / data_readRegB                    : read port B
//   ctrl_issue / ctrl_issueReg                       : marks a destination as pending
//   busy_A / busy_B                                  : scoreboard bit of each read address
//   dbg_addr / dbg_data                              : registered debug tap
//
// Modports:
//   master - the decode stage that drives requests
//   slave  - the register file
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [WIDTH-1:0]  data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [WIDTH-1:0]  data_readRegA;
  logic [WIDTH-1:0]  data_readRegB;
  logic              ctrl_issue;
  logic [ADDR_W-1:0] ctrl_issueReg;
  logic              busy_A;
  logic              busy_B;
  logic [ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output ctrl_issue, ctrl_issueReg,
    output dbg_addr,
    input  data_readRegA, data_readRegB,
    input  busy_A, busy_B,
    input  dbg_data
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  ctrl_issue, ctrl_issueReg,
    input  dbg_addr,
    output data_readRegA, data_readRegB,
    output busy_A, busy_B,
    output dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with two combinational read ports, one write port and a
// pending-write scoreboard (one busy bit per register) for RAW-hazard stalls
// in the decode stage. Entry 0 is hardwired to zero and is never busy.
// A registered debug tap returns the pre-write contents of dbg_addr one
// cycle later.
//
// Ports:
//   clock      - single clock, all state updates on the rising edge
//   ctrl_reset - asynchronous active-high reset (clears entries, busy bits, tap)
//   bus        - regfile_sb_if.slave (write, read A/B, issue, busy, debug tap)
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a same-cycle write to the register being
//                       read is forwarded to that read port, and its busy
//                       output is forced low unless the same register is being
//                       issued in that cycle. Undefined (default): read ports
//                       and busy outputs reflect stored state only.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] entry_q;
  logic [DEPTH-1:0][WIDTH-1:0] entry_d;
  logic [DEPTH-1:0]            busy_q;
  logic [DEPTH-1:0]            busy_d;
  logic [WIDTH-1:0]            dbg_data_q;
  logic [WIDTH-1:0]            dbg_data_d;

  logic wr_valid;
  logic iss_valid;

  // Address 0 is ignored for writes, issues and clears alike.
  always_comb begin
    wr_valid  = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);
    iss_valid = bus.ctrl_issue && (bus.ctrl_issueReg != '0);
  end

  always_comb begin
    entry_d = entry_q;
    if (wr_valid) begin
      entry_d[bus.ctrl_writeReg] = bus.data_writeReg;
    end
    entry_d[0] = '0;
  end

  // Clear first, then set: when issue and write hit the same register the
  // new producer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[bus.ctrl_writeReg] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[bus.ctrl_issueReg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // The tap reads the stored array, so a same-cycle write shows up one
  // cycle later.
  always_comb begin
    dbg_data_d = entry_q[bus.dbg_addr];
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      entry_q    <= '0;
      busy_q     <= '0;
      dbg_data_q <= '0;
    end else begin
      entry_q    <= entry_d;
      busy_q     <= busy_d;
      dbg_data_q <= dbg_data_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;
  logic iss_same;

  // Forwarding is suppressed during reset so the ports read zero while
  // ctrl_reset is high.
  always_comb begin
    iss_same = iss_valid && (bus.ctrl_issueReg == bus.ctrl_writeReg);
    fwd_a    = wr_valid && !ctrl_reset && (bus.ctrl_readRegA == bus.ctrl_writeReg);
    fwd_b    = wr_valid && !ctrl_reset && (bus.ctrl_readRegB == bus.ctrl_writeReg);

    bus.data_readRegA = fwd_a ? bus.data_writeReg : entry_q[bus.ctrl_readRegA];
    bus.data_readRegB = fwd_b ? bus.data_writeReg : entry_q[bus.ctrl_readRegB];
    bus.busy_A        = (fwd_a && !iss_same) ? 1'b0 : busy_q[bus.ctrl_readRegA];
    bus.busy_B        = (fwd_b && !iss_same) ? 1'b0 : busy_q[bus.ctrl_readRegB];
  end
`else
  always_comb begin
    bus.data_readRegA = entry_q[bus.ctrl_readRegA];
    bus.data_readRegB = entry_q[bus.ctrl_readRegB];
    bus.busy_A        = busy_q[bus.ctrl_readRegA];
    bus.busy_B        = busy_q[bus.ctrl_readRegB];
  end
`endif

  assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb. Each vector holds one cycle of inputs
// plus the outputs expected during that cycle (before the committing edge).
// Expected records are queued when a vector is driven and popped when the
// outputs are sampled.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        iss;
    logic [4:0]  ir;
    logic [4:0]  da;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eba;
    logic        ebb;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic [31:0] d;
    int          id;
  } exp_t;

  logic clock;
  logic ctrl_reset;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  localparam int NV = 23;
  vec_t tbl[NV];

  regfile_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic iss, input logic [4:0] ir, input logic [4:0] da,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic eba, input logic ebb, input logic [31:0] ed);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.ra = ra; v.rb = rb;
    v.iss = iss; v.ir = ir; v.da = da;
    v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.ed = ed;
    return v;
  endfunction

  task automatic compare_field(input string name, input int id,
                               input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int id);
    exp_t e;
    bus.ctrl_writeEnable = v.we;
    bus.ctrl_writeReg    = v.wr;
    bus.data_writeReg    = v.wd;
    bus.ctrl_readRegA    = v.ra;
    bus.ctrl_readRegB    = v.rb;
    bus.ctrl_issue       = v.iss;
    bus.ctrl_issueReg    = v.ir;
    bus.dbg_addr         = v.da;
    e.a = v.ea; e.b = v.eb; e.ba = v.eba; e.bb = v.ebb; e.d = v.ed; e.id = id;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    #2;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending record");
    end else begin
      compared--;
      e = sb_q.pop_front();
      compare_field("data_readRegA", e.id, bus.data_readRegA, e.a);
      compare_field("data_readRegB", e.id, bus.data_readRegB, e.b);
      compare_field("busy_A", e.id, {31'b0, bus.busy_A}, {31'b0, e.ba});
      compare_field("busy_B", e.id, {31'b0, bus.busy_B}, {31'b0, e.bb});
      compare_field("dbg_data", e.id, bus.dbg_data, e.d);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    apply_stimulus(v, id);
    check_output();
    @(negedge clock);
  endtask

  initial begin
    // Main table: r0 protection, dual-port reads, scoreboard, forwarding, debug tap.
    tbl[0]  = mk(1, 0, 32'h12345678, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 8, 32'hA5A5A5A5, 8, 31, 0, 0, 8,
                 BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 31, 32'h5A5A5A5A, 8, 31, 0, 0, 8,
                 32'hA5A5A5A5, BYP ? 32'h5A5A5A5A : 32'h0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 8, 31, 0, 0, 31,
                 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 32'hA5A5A5A5);
    tbl[5]  = mk(0, 0, 0, 8, 8, 0, 0, 0,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'h5A5A5A5A);
    tbl[6]  = mk(0, 0, 0, 10, 8, 1, 10, 0,            0, 32'hA5A5A5A5, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 10, 10, 0, 0, 0,            0, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 10, 10, 0, 0, 0,            0, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 10, 10, 0, 0, 0,            0, 0, 1, 1, 0);
    tbl[10] = mk(1, 10, 32'h7, 10, 10, 0, 0, 0,
                 BYP ? 32'h7 : 32'h0, BYP ? 32'h7 : 32'h0, !BYP, !BYP, 0);
    tbl[11] = mk(0, 0, 0, 10, 0, 0, 0, 0,             32'h7, 0, 0, 0, 0);
    tbl[12] = mk(1, 10, 32'h9, 10, 10, 1, 10, 0,
                 BYP ? 32'h9 : 32'h7, BYP ? 32'h9 : 32'h7, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 10, 10, 0, 0, 0,            32'h9, 32'h9, 1, 1, 0);
    tbl[14] = mk(1, 10, 32'h9, 10, 0, 0, 0, 0,        32'h9, 0, !BYP, 0, 0);
    tbl[15] = mk(1, 12, 32'h0000BEEF, 12, 10, 0, 0, 0,
                 BYP ? 32'h0000BEEF : 32'h0, 32'h9, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 12, 0, 0, 0, 0,             32'h0000BEEF, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 30,             0, 0, 0, 0, 0);
    tbl[18] = mk(1, 30, 32'h42, 30, 0, 0, 0, 30,
                 BYP ? 32'h42 : 32'h0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 30, 0, 0, 0, 30,            32'h42, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 30, 0, 0, 0, 30,            32'h42, 0, 0, 0, 32'h42);
    tbl[21] = mk(0, 0, 0, 3, 10, 1, 3, 30,            0, 32'h9, 0, 0, 32'h42);
    tbl[22] = mk(0, 0, 0, 3, 10, 0, 0, 30,            0, 32'h9, 1, 0, 32'h42);

    ctrl_reset = 1'b1;
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 99);
    void'(sb_q.pop_back());
    @(negedge clock);

    // Reset values, then write r5 and mark it busy before a 2-cycle reset.
    run_vec(mk(0, 0, 0, 5, 5, 0, 0, 5,   0, 0, 0, 0, 0), 100);
    ctrl_reset = 1'b0;
    run_vec(mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 5,
               BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0), 101);
    run_vec(mk(0, 0, 0, 5, 0, 1, 5, 5,   32'hDEADBEEF, 0, 0, 0, 0), 102);
    run_vec(mk(0, 0, 0, 5, 5, 0, 0, 5,
               32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF), 103);
    ctrl_reset = 1'b1;
    run_vec(mk(1, 5, 32'hDEADBEEF, 5, 5, 1, 5, 5,   0, 0, 0, 0, 0), 104);
    run_vec(mk(1, 5, 32'hDEADBEEF, 5, 5, 1, 5, 5,   0, 0, 0, 0, 0), 105);
    ctrl_reset = 1'b0;
    run_vec(mk(0, 0, 0, 5, 5, 0, 0, 5,   0, 0, 0, 0, 0), 106);
    run_vec(mk(0, 0, 0, 5, 5, 0, 0, 5,   0, 0, 0, 0, 0), 107);

    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], i);
    end

    // Mid-operation reset cancels the outstanding busy bit on r3.
    ctrl_reset = 1'b1;
    run_vec(mk(0, 0, 0, 3, 30, 0, 0, 30,   0, 0, 0, 0, 0), 200);
    ctrl_reset = 1'b0;
    run_vec(mk(0, 0, 0, 3, 10, 0, 0, 30,   0, 0, 0, 0, 0), 201);

    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d records, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
